// File: rtl/serial_acc.sv
// rtl/serial_acc.sv - block accumulator: sums n_i samples per start, holds the result until taken
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   start_i      begin a new block of n_i samples (honoured in IDLE, or in HOLD when the result is taken)
//   n_i          block length, sampled only when a start is accepted
//   abort_i      drop the block in progress (ACC only)
//   in_valid_i   data_i carries a sample
//   data_i       sample, two's complement when SIGNED_EN=1, unsigned otherwise
//   in_ready_o   a sample is accepted this cycle (state ACC)
//   out_valid_o  sum_o carries a finished result (state HOLD)
//   out_ready_i  consumer takes the result
//   sum_o        accumulator, always visible, qualified by out_valid_o
//   remain_o     samples still owed in the current block
//   busy_o       block in progress (state ACC)

module serial_acc #(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter int SUM_W     = DATA_W + CNT_W,
    parameter int SIGNED_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  n_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic [CNT_W-1:0]  remain_o,
    output logic              busy_o
);

    // A block of at most 2^CNT_W-1 samples of DATA_W bits cannot exceed
    // DATA_W+CNT_W bits, so anything narrower could wrap silently.
    generate
        if (SUM_W < DATA_W + CNT_W) begin : g_bad_sum_w
            $error("serial_acc: SUM_W must be at least DATA_W+CNT_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   remain_q, remain_d;
    logic [SUM_W-1:0]   sample_ext;
    logic               start_ok;

    generate
        if (SIGNED_EN != 0) begin : g_sext
            assign sample_ext = {{(SUM_W-DATA_W){data_i[DATA_W-1]}}, data_i};
        end else begin : g_zext
            assign sample_ext = {{(SUM_W-DATA_W){1'b0}}, data_i};
        end
    endgenerate

    // A start is honoured from IDLE, or from HOLD in the same cycle the
    // result is consumed so back-to-back blocks need no idle cycle.
    assign start_ok = start_i &&
                      ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        remain_d = remain_q;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                // Result taken without a follow-on start: back to idle, keep
                // the last sum on sum_o.
                if ((state_q == ST_HOLD) && out_ready_i) begin
                    state_d = ST_IDLE;
                end
                if (start_ok) begin
                    acc_d = '0;
                    if (n_i != '0) begin
                        remain_d = n_i;
                        state_d  = ST_ACC;
                    end else begin
                        // Empty block: report a zero result straight away.
                        remain_d = '0;
                        state_d  = ST_HOLD;
                    end
                end
            end

            ST_ACC: begin
                if (abort_i) begin
                    // Abort wins over a sample presented in the same cycle.
                    state_d  = ST_IDLE;
                    acc_d    = '0;
                    remain_d = '0;
                end else if (in_valid_i) begin
                    acc_d    = acc_q + sample_ext;
                    remain_d = remain_q - CNT_W'(1);
                    if (remain_q == CNT_W'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                acc_d    = '0;
                remain_d = '0;
            end
        endcase
    end

    assign in_ready_o  = (state_q == ST_ACC);
    assign busy_o      = (state_q == ST_ACC);
    assign out_valid_o = (state_q == ST_HOLD);
    assign sum_o       = acc_q;
    assign remain_o    = remain_q;

endmodule

// File: doc/serial_acc.md
SERIAL_ACC -- requirements
Module: serial_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the sample width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the sample-count field.
REQ-003 SHALL have parameter SUM_W, default DATA_W+CNT_W, giving the result width; elaboration SHALL fail if SUM_W < DATA_W+CNT_W.
REQ-004 SHALL have parameter SIGNED_EN, default 1; 1 means samples are two's complement, 0 means unsigned.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  reset; asynchronous assert, active-low.
REQ-007 start_i  input  1  request to begin a new block of n_i samples.
REQ-008 n_i  input  CNT_W  unsigned sample count, sampled only when a start is accepted.
REQ-009 abort_i  input  1  discards the block in progress.
REQ-010 in_valid_i  input  1  data_i holds a valid sample.
REQ-011 data_i  input  DATA_W  sample value.
REQ-012 in_ready_o  output  1  block accepts a sample this cycle.
REQ-013 out_valid_o  output  1  sum_o holds a completed result.
REQ-014 out_ready_i  input  1  consumer takes the result.
REQ-015 sum_o  output  SUM_W  accumulated result, signed when SIGNED_EN=1.
REQ-016 remain_o  output  CNT_W  samples still to be accepted in the current block.
REQ-017 busy_o  output  1  high in state ACC.

Function
REQ-018 SHALL implement an FSM with states IDLE, ACC and HOLD.
REQ-019 IDLE: in_ready_o=0 and out_valid_o=0; start_i=1 with n_i!=0 SHALL latch n_i into remain, clear the accumulator and go to ACC.
REQ-020 IDLE: start_i=1 with n_i=0 SHALL clear the accumulator and go to HOLD, so out_valid_o=1 with sum_o=0 on the next cycle.
REQ-021 ACC: in_ready_o=1; a handshake (in_valid_i & in_ready_o) SHALL add the sample to the accumulator and decrement remain by 1.
REQ-022 Samples SHALL be extended to SUM_W bits: sign-extended when SIGNED_EN=1, zero-extended when SIGNED_EN=0.
REQ-023 A cycle in ACC with in_valid_i=0 SHALL leave the accumulator and remain unchanged.
REQ-024 The handshake that takes remain from 1 to 0 SHALL move the FSM to HOLD; out_valid_o SHALL rise on the next edge (latency 1 cycle after the last sample).
REQ-025 HOLD: out_valid_o=1, in_ready_o=0, and sum_o SHALL stay stable until out_ready_i=1.
REQ-026 HOLD with out_ready_i=1 and start_i=0 SHALL go to IDLE.
REQ-027 HOLD with out_ready_i=1 and start_i=1 SHALL start the next block directly (ACC, or HOLD if n_i=0) with no idle cycle.
REQ-028 start_i SHALL be ignored in ACC, and in HOLD while out_ready_i=0.
REQ-029 abort_i=1 in ACC SHALL go to IDLE, clear the accumulator and remain, and discard any sample presented in the same cycle.
REQ-030 abort_i SHALL have no effect in IDLE or HOLD.
REQ-031 The accumulator SHALL never overflow, because SUM_W >= DATA_W+CNT_W; no saturation logic is required.
REQ-032 sum_o SHALL show the accumulator value in all states; it is qualified only by out_valid_o.
REQ-033 remain_o SHALL equal the remain register; it is 0 in IDLE and HOLD.

Reset
REQ-034 rst_ni=0 SHALL immediately force: state IDLE, accumulator 0, remain 0, sum_o=0, remain_o=0, in_ready_o=0, out_valid_o=0, busy_o=0.
REQ-035 Reset asserted mid-block (ACC or HOLD) SHALL discard the partial or pending result; no out_valid_o SHALL follow reset release.
REQ-036 After rst_ni deasserts, the first rising edge SHALL be able to accept start_i.

Verification
REQ-037 Defaults, SIGNED_EN=1: start with n_i=4, samples 5,-3,127,-128 with in_valid_i held high -> out_valid_o rises 1 cycle after the 4th sample, sum_o=16'h0001.
REQ-038 SIGNED_EN=0: n_i=3, samples 8'hFF x3 -> sum_o=16'h02FD.
REQ-039 n_i=0 -> out_valid_o=1 with sum_o=0 on the next cycle; n_i=255, all samples -128 -> sum_o=-32640 (16'h8080), with no overflow.
REQ-040 Backpressure: in_valid_i gapped randomly and out_ready_i held low 5 cycles -> sum matches a reference model and sum_o stays stable during HOLD; start_i held with out_ready_i -> next block begins with no idle cycle.
REQ-041 abort_i after 2 of 4 samples -> IDLE, no out_valid_o; a following block of n_i=2 with samples 1,1 -> sum_o=2.
REQ-042 rst_ni pulsed low asynchronously (between clock edges) during ACC and during HOLD -> all outputs 0 immediately, and no stale out_valid_o after reset release.
